// File: rtl/hififo_tx_wr_tlp.sv
// Burst-to-TLP formatter. Write bursts are captured into a payload ring
// buffer and a descriptor queue. Each burst is then emitted as one PCIe Memory
// Write TLP (3DW or 4DW header) on a 64-bit valid/ready/last/keep stream.
// Handshake: on the tx side a beat transfers on a cycle where tx_valid and
// tx_ready are both high, and tx_data/tx_keep/tx_last hold while stalled.
// On the wr side, wr_ready is a one-cycle accept pulse and the burst data
// follows on consecutive cycles starting with that cycle.
module hififo_tx_wr_tlp #(
  parameter int MAX_BURST  = 16,
  parameter int DATA_DEPTH = 64,
  parameter int CMD_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pci_id,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [63:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic [4:0]  wr_count,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [63:0] tx_data,
  output logic        tx_last,
  output logic [7:0]  tx_keep,
  output logic        error
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int CAW = $clog2(CMD_DEPTH);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;
  state_t state;

  // payload ring and descriptor queue
  logic [63:0]    mem [DATA_DEPTH];
  logic [DAW-1:0] wr_ptr, rd_ptr;
  logic [DAW:0]   used;
  logic [DAW:0]   free_words;
  logic [63:0]    cmd_addr [CMD_DEPTH];
  logic [4:0]     cmd_n [CMD_DEPTH];
  logic [CAW-1:0] cmd_wp, cmd_rp;
  logic [CAW:0]   cmd_cnt;

  // capture side
  logic        wr_ready_q, capturing;
  logic [4:0]  cap_left, cap_n, hold_cnt;
  logic [63:0] cap_addr;
  logic        legal, accept, wr_en, push, pop, fire;
  logic [63:0] push_addr;
  logic [4:0]  push_n;

  // emit side
  logic [4:0]     rem;
  logic [31:0]    hi_q;
  logic           cur_4dw;
  logic [63:0]    rd_word, cur_addr, hdr_addr;
  logic [4:0]     hdr_n;
  logic           hdr_4dw;
  logic [CAW-1:0] hdr_idx;
  logic [63:0]    hdr0_beat, hdr1_beat, nxt_data;
  logic           nxt_last, nxt_consume;
  logic [7:0]     nxt_keep;

  assign free_words = (DAW+1)'(DATA_DEPTH) - used;
  assign legal      = (wr_count != 5'd0) && (wr_count <= 5'(MAX_BURST));
  assign accept     = wr_valid & ~reset & ~capturing & (hold_cnt == 5'd0) &
                      (free_words >= (DAW+1)'(MAX_BURST)) &
                      (cmd_cnt != (CAW+1)'(CMD_DEPTH)) & ~wr_ready_q;
  assign wr_ready   = accept;
  assign wr_en      = (accept & legal) | capturing;
  assign push       = (accept & legal & (wr_count == 5'd1)) | (capturing & (cap_left == 5'd1));
  assign push_addr  = capturing ? cap_addr : wr_addr;
  assign push_n     = capturing ? cap_n : wr_count;
  assign fire       = tx_valid & tx_ready;
  assign pop        = fire & tx_last;

  assign rd_word   = mem[rd_ptr];
  assign cur_addr  = cmd_addr[cmd_rp];
  // IDLE starts from the queue head; a back-to-back TLP starts from the entry behind it
  assign hdr_idx   = (state == IDLE) ? cmd_rp : CAW'(cmd_rp + 1'b1);
  assign hdr_addr  = cmd_addr[hdr_idx];
  assign hdr_n     = cmd_n[hdr_idx];
  assign hdr_4dw   = |hdr_addr[63:32];
  assign hdr0_beat = {pci_id, 8'h00, 4'hF, 4'hF,
                      1'b0, (hdr_4dw ? 2'b11 : 2'b10), 5'b00000, 14'b0, 4'b0, hdr_n, 1'b0};
  assign hdr1_beat = cur_4dw ? {cur_addr[31:0], cur_addr[63:32]}
                             : {rd_word[31:0], cur_addr[31:0]};

  // next payload beat; 3DW beats straddle two qwords, hence the held high half
  always_comb begin
    nxt_data    = rd_word;
    nxt_last    = (rem == 5'd1);
    nxt_keep    = 8'hFF;
    nxt_consume = 1'b1;
    if (!cur_4dw) begin
      if (rem != 5'd0) begin
        nxt_data = {rd_word[31:0], hi_q};
        nxt_last = 1'b0;
      end else begin
        nxt_data    = {32'h0, hi_q};
        nxt_last    = 1'b1;
        nxt_keep    = 8'h0F;
        nxt_consume = 1'b0;
      end
    end
  end

  // payload write port (no reset needed; occupancy is tracked by used)
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // descriptor storage
  always_ff @(posedge clock) begin
    if (push) begin
      cmd_addr[cmd_wp] <= push_addr;
      cmd_n[cmd_wp]    <= push_n;
    end
  end

  // capture control, occupancy counters and error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ready_q <= 1'b0;
      capturing  <= 1'b0;
      cap_left   <= 5'd0;
      cap_n      <= 5'd0;
      cap_addr   <= 64'h0;
      hold_cnt   <= 5'd0;
      wr_ptr     <= '0;
      used       <= '0;
      cmd_wp     <= '0;
      cmd_rp     <= '0;
      cmd_cnt    <= '0;
      error      <= 1'b0;
    end else begin
      wr_ready_q <= accept;
      if (hold_cnt != 5'd0) hold_cnt <= hold_cnt - 5'd1;
      if (accept) begin
        cap_addr <= wr_addr;
        cap_n    <= wr_count;
        if (!legal) error <= 1'b1;
        if (wr_count > 5'(MAX_BURST)) hold_cnt <= wr_count;
        if (legal && wr_count != 5'd1) begin
          capturing <= 1'b1;
          cap_left  <= wr_count - 5'd1;
        end
      end else if (capturing) begin
        cap_left <= cap_left - 5'd1;
        if (cap_left == 5'd1) capturing <= 1'b0;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      used <= used + (DAW+1)'(wr_en) - (pop ? (DAW+1)'(cmd_n[cmd_rp]) : '0);
      if (push) cmd_wp <= cmd_wp + 1'b1;
      if (pop)  cmd_rp <= cmd_rp + 1'b1;
      if (push && !pop)      cmd_cnt <= cmd_cnt + 1'b1;
      else if (pop && !push) cmd_cnt <= cmd_cnt - 1'b1;
    end
  end

  // emit FSM with registered stream outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 64'h0;
      tx_last  <= 1'b0;
      tx_keep  <= 8'h00;
      rem      <= 5'd0;
      hi_q     <= 32'h0;
      cur_4dw  <= 1'b0;
      rd_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_cnt != '0) begin
            tx_valid <= 1'b1;
            tx_data  <= hdr0_beat;
            tx_last  <= 1'b0;
            tx_keep  <= 8'hFF;
            cur_4dw  <= hdr_4dw;
            state    <= HDR0;
          end
        end
        HDR0: begin
          if (fire) begin
            tx_data <= hdr1_beat;
            state   <= HDR1;
            if (cur_4dw) begin
              rem <= cmd_n[cmd_rp];
            end else begin
              rem    <= cmd_n[cmd_rp] - 5'd1;
              hi_q   <= rd_word[63:32];
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        HDR1, DATA: begin
          if (fire) begin
            if (state == DATA && tx_last) begin
              if (cmd_cnt >= (CAW+1)'(2)) begin
                tx_data <= hdr0_beat;
                tx_last <= 1'b0;
                tx_keep <= 8'hFF;
                cur_4dw <= hdr_4dw;
                state   <= HDR0;
              end else begin
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
                tx_keep  <= 8'h00;
                state    <= IDLE;
              end
            end else begin
              tx_data <= nxt_data;
              tx_last <= nxt_last;
              tx_keep <= nxt_keep;
              state   <= DATA;
              if (nxt_consume) begin
                rd_ptr <= rd_ptr + 1'b1;
                rem    <= rem - 5'd1;
                hi_q   <= rd_word[63:32];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hififo_tx_wr_tlp.sv
// Bench for hififo_tx_wr_tlp: bursts are offered by driver tasks, the expected
// TLP beats are derived from the wire-level DW sequence and queued, and a
// monitor pops and compares every transferred beat.
module tb_hififo_tx_wr_tlp;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pci_id = 16'hBEEF;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_addr = 64'h0;
  logic [63:0] wr_data = 64'h0;
  logic [4:0]  wr_count = 5'd0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [63:0] tx_data;
  logic        tx_last;
  logic [7:0]  tx_keep;
  logic        error;

  hififo_tx_wr_tlp dut (
    .clock(clock), .reset(reset), .pci_id(pci_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_count(wr_count),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .tx_keep(tx_keep), .error(error)
  );

  // clock and watchdog
  always #5 clock = ~clock;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state; entries are {keep[7:0], last, data[63:0]}
  logic [72:0] exp_q[$];
  logic [72:0] got_q[$];
  logic [63:0] bw[16];
  int n_vec = 0;
  int n_err = 0;
  int lasts = 0;
  int tlps_expected = 0;
  int beats_seen = 0;
  int ready_mode = 1;   // 0: stall, 1: always ready, 2: random 50%

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: lay out the TLP as a DW sequence, then pair DWs into beats
  function automatic void push_expected(input logic [63:0] a, input int n);
    logic [31:0] dws[$];
    logic        four;
    logic [31:0] lo, hi;
    four = (a[63:32] != 32'h0);
    dws.push_back({1'b0, (four ? 2'b11 : 2'b10), 5'b0, 14'b0, 10'(2 * n)});
    dws.push_back({pci_id, 8'h00, 8'hFF});
    if (four) begin
      dws.push_back(a[63:32]);
      dws.push_back(a[31:0]);
    end else begin
      dws.push_back(a[31:0]);
    end
    for (int k = 0; k < n; k++) begin
      dws.push_back(bw[k][31:0]);
      dws.push_back(bw[k][63:32]);
    end
    for (int i = 0; i < dws.size(); i += 2) begin
      lo = dws[i];
      hi = (i + 1 < dws.size()) ? dws[i+1] : 32'h0;
      exp_q.push_back({((i + 1 < dws.size()) ? 8'hFF : 8'h0F), (i + 2 >= dws.size()), hi, lo});
    end
    tlps_expected++;
  endfunction

  // tx_ready driver
  always @(negedge clock) begin
    case (ready_mode)
      0: tx_ready = 1'b0;
      1: tx_ready = 1'b1;
      default: tx_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // monitor: compare each transferred beat, check stability while stalled
  logic [72:0] stall_beat;
  logic        have_stall = 1'b0;
  always @(negedge clock) begin
    logic [72:0] cur;
    logic [72:0] e;
    #1;
    if (reset) begin
      have_stall = 1'b0;
    end else begin
      cur = {tx_keep, tx_last, tx_data};
      if (have_stall) begin
        n_vec++;
        if (!tx_valid || cur !== stall_beat) begin
          n_err++;
          $display("FAIL stall_stable: got valid=%b %h expected %h", tx_valid, cur, stall_beat);
        end
      end
      have_stall = 1'b0;
      if (tx_valid) begin
        if (tx_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: got %h expected no beat", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_err++;
              $display("FAIL beat: got %h expected %h", cur, e);
            end
          end
          got_q.push_back(cur);
          beats_seen++;
          if (tx_last) lasts++;
        end else begin
          have_stall = 1'b1;
          stall_beat = cur;
        end
      end
    end
  end

  // driver: offer a burst using bw[], wait up to budget cycles for wr_ready
  task automatic offer(input logic [63:0] a, input int n, input int budget, output bit acc);
    int nd;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_count = 5'(n);
    wr_data  = bw[0];
    acc = 1'b0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (wr_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!acc) begin
      wr_valid = 1'b0;
      return;
    end
    if (n >= 1 && n <= 16) push_expected(a, n);
    nd = (n >= 1 && n <= 16) ? n : 0;
    @(posedge clock);
    for (int k = 1; k < nd; k++) begin
      @(negedge clock);
      wr_valid = 1'b0;
      wr_data  = bw[k];
    end
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      #2;
      if (exp_q.size() == 0 && !tx_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_drained"}, 73'(done), 73'(1));
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a[63:32] = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0;
    a[31:0]  = 32'($urandom) & 32'hFFFF_FFF8;
    return a;
  endfunction

  initial begin
    bit acc;
    int acc_count;
    int base;
    int l0;

    // reset block
    repeat (3) @(negedge clock);
    #1;
    chk("reset_tx_valid", 73'(tx_valid), 73'(0));
    chk("reset_tx_last",  73'(tx_last),  73'(0));
    chk("reset_tx_keep",  73'(tx_keep),  73'(0));
    chk("reset_error",    73'(error),    73'(0));
    chk("reset_wr_ready", 73'(wr_ready), 73'(0));
    @(negedge clock);
    reset = 1'b0;

    // 3DW directed burst
    ready_mode = 1;
    got_q.delete();
    for (int k = 0; k < 16; k++) bw[k] = 64'(k);
    offer(64'h0000_0000_1000_0000, 16, 50, acc);
    chk("t1_accept", 73'(acc), 73'(1));
    wait_drain("t1", 200);
    chk("t1_beats", 73'(got_q.size()), 73'(18));
    if (got_q.size() == 18) begin
      chk("t1_dw0",   73'(got_q[0][31:0]), 73'(32'h4000_0020));
      chk("t1_dw1",   73'(got_q[0][63:32]), 73'({16'hBEEF, 16'h00FF}));
      chk("t1_beat1", 73'(got_q[1][63:0]), 73'(64'h0000_0000_1000_0000));
      chk("t1_beat17", got_q[17], {8'h0F, 1'b1, 64'h0});
    end

    // 4DW directed burst
    got_q.delete();
    offer(64'h0000_0001_0000_0040, 16, 50, acc);
    chk("t2_accept", 73'(acc), 73'(1));
    wait_drain("t2", 200);
    chk("t2_beats", 73'(got_q.size()), 73'(18));
    if (got_q.size() == 18) begin
      chk("t2_dw0",    73'(got_q[0][31:0]), 73'(32'h6000_0020));
      chk("t2_beat1",  73'(got_q[1][63:0]), 73'(64'h0000_0040_0000_0001));
      chk("t2_beat2",  got_q[2], {8'hFF, 1'b0, 64'h0});
      chk("t2_beat17", got_q[17], {8'hFF, 1'b1, 64'd15});
    end

    // randomized bursts with random back-pressure
    ready_mode = 2;
    for (int b = 0; b < 14; b++) begin
      int n;
      logic [63:0] a;
      n = $urandom_range(1, 16);
      a = rand_addr();
      for (int k = 0; k < 16; k++) bw[k] = {32'($urandom), 32'($urandom)};
      offer(a, n, 400, acc);
      chk("t3_accept", 73'(acc), 73'(1));
    end
    wait_drain("t3", 3000);

    // full stall: buffers fill after four 16-qword bursts
    ready_mode = 0;
    acc_count = 0;
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 16; k++) bw[k] = {32'($urandom), 32'($urandom)};
      offer(rand_addr(), 16, 40, acc);
      if (acc) acc_count++;
    end
    chk("t4_accepted", 73'(acc_count), 73'(4));
    ready_mode = 1;
    wait_drain("t4", 1000);

    // reset in the middle of a TLP
    base = beats_seen;
    for (int k = 0; k < 16; k++) bw[k] = {32'($urandom), 32'($urandom)};
    offer(64'h0000_0000_2000_0000, 16, 50, acc);
    chk("t6_accept", 73'(acc), 73'(1));
    acc = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      #2;
      if (beats_seen >= base + 5) begin
        acc = 1'b1;
        break;
      end
    end
    chk("t6_reached_beat5", 73'(acc), 73'(1));
    reset = 1'b1;
    exp_q.delete();
    tlps_expected--;
    l0 = lasts;
    @(negedge clock);
    reset = 1'b0;
    #2;
    chk("t6_tx_valid_after_reset", 73'(tx_valid), 73'(0));
    repeat (30) @(negedge clock);
    #2;
    chk("t6_no_partial", 73'(lasts - l0), 73'(0));
    for (int k = 0; k < 16; k++) bw[k] = {32'($urandom), 32'($urandom)};
    offer(rand_addr(), $urandom_range(1, 16), 50, acc);
    chk("t6_clean_accept", 73'(acc), 73'(1));
    wait_drain("t6", 300);

    // illegal counts
    chk("t5_error_before", 73'(error), 73'(0));
    l0 = lasts;
    got_q.delete();
    offer(64'h0000_0000_3000_0000, 0, 50, acc);
    chk("t5_zero_accept", 73'(acc), 73'(1));
    for (int k = 0; k < 16; k++) bw[k] = {32'($urandom), 32'($urandom)};
    offer(64'h0000_0000_3000_0100, 3, 50, acc);
    chk("t5_three_accept", 73'(acc), 73'(1));
    wait_drain("t5", 200);
    chk("t5_error", 73'(error), 73'(1));
    chk("t5_one_tlp", 73'(lasts - l0), 73'(1));
    if (got_q.size() > 0) chk("t5_length", 73'(got_q[0][9:0]), 73'(6));
    l0 = lasts;
    offer(64'h0000_0000_3000_0200, 20, 50, acc);
    chk("t5_big_accept", 73'(acc), 73'(1));
    repeat (40) @(negedge clock);
    #2;
    chk("t5_big_no_tlp", 73'(lasts - l0), 73'(0));
    chk("t5_error_sticky", 73'(error), 73'(1));

    // final report
    chk("final_queue_empty", 73'(exp_q.size()), 73'(0));
    chk("final_lasts", 73'(lasts), 73'(tlps_expected));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
